// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: opcodes, FSM encoding and
// the fixed register-file slots used for ALU operands.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_ALU_OPA = 3'd4,
    ST_ALU_OPB = 3'd5,
    ST_ALU_FUN = 3'd6,
    ST_NOP_FUN = 3'd7
  } cmd_state_t;

endpackage : uart_cmd_pkg

// File: rtl/uart_cmd_timeout.sv
// Saturating inter-frame counter; timeout_o is high while the count sits at
// TIMEOUT_CYCLES-1 and drops as soon as clear_i is seen.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_q;

  // Next count: clear, hold at the ceiling, or step by one.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register and registered timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= (cnt_d == CNT_MAX);
    end
  end

  assign timeout_o = timeout_q;

endmodule : uart_cmd_timeout

// File: rtl/uart_rx_cmd_decoder.sv
// Decodes multi-frame UART commands into single-cycle register-file write/read
// and ALU requests; aborts on frame errors or inter-frame timeout.
module uart_rx_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned ALU_FUN_WIDTH  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     rx_clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    p_data,
  input  logic                     data_valid,
  input  logic                     parity_error,
  input  logic                     stop_error,
  output logic                     rf_wr_en,
  output logic                     rf_rd_en,
  output logic [ADDR_WIDTH-1:0]    rf_addr,
  output logic [DATA_WIDTH-1:0]    rf_wr_data,
  output logic                     alu_en,
  output logic [ALU_FUN_WIDTH-1:0] alu_fun,
  output logic                     cmd_busy,
  output logic                     cmd_error
);

  cmd_state_t               state_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     rf_wr_en_q;
  logic                     rf_rd_en_q;
  logic [ADDR_WIDTH-1:0]    rf_addr_q;
  logic [DATA_WIDTH-1:0]    rf_wr_data_q;
  logic                     alu_en_q;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q;
  logic                     cmd_busy_q;
  logic                     cmd_error_q;

  logic in_cmd_s;
  logic frame_err_s;
  logic timeout_s;
  logic tmo_clear_s;

  assign in_cmd_s    = (state_q != ST_IDLE);
  assign frame_err_s = parity_error | stop_error;
  assign tmo_clear_s = data_valid | ~in_cmd_s;

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (rx_clk),
    .rst_ni   (rst_n),
    .clear_i  (tmo_clear_s),
    .timeout_o(timeout_s)
  );

  // Command FSM with registered strobes; frame error beats data_valid, data_valid beats timeout.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      cmd_busy_q   <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      rf_wr_en_q  <= 1'b0;
      rf_rd_en_q  <= 1'b0;
      alu_en_q    <= 1'b0;
      cmd_error_q <= 1'b0;
      if (in_cmd_s && frame_err_s) begin
        state_q     <= ST_IDLE;
        cmd_busy_q  <= 1'b0;
        cmd_error_q <= 1'b1;
      end else if (data_valid) begin
        case (state_q)
          ST_IDLE: begin
            case (p_data)
              DATA_WIDTH'(CMD_RF_WR):   begin state_q <= ST_WR_ADDR; cmd_busy_q <= 1'b1; end
              DATA_WIDTH'(CMD_RF_RD):   begin state_q <= ST_RD_ADDR; cmd_busy_q <= 1'b1; end
              DATA_WIDTH'(CMD_ALU_OP):  begin state_q <= ST_ALU_OPA; cmd_busy_q <= 1'b1; end
              DATA_WIDTH'(CMD_ALU_NOP): begin state_q <= ST_NOP_FUN; cmd_busy_q <= 1'b1; end
              default: begin
                state_q    <= ST_IDLE;
                cmd_busy_q <= 1'b0;
              end
            endcase
          end
          ST_WR_ADDR: begin
            addr_q  <= p_data[ADDR_WIDTH-1:0];
            state_q <= ST_WR_DATA;
          end
          ST_WR_DATA: begin
            rf_wr_en_q   <= 1'b1;
            rf_addr_q    <= addr_q;
            rf_wr_data_q <= p_data;
            state_q      <= ST_IDLE;
            cmd_busy_q   <= 1'b0;
          end
          ST_RD_ADDR: begin
            rf_rd_en_q <= 1'b1;
            rf_addr_q  <= p_data[ADDR_WIDTH-1:0];
            state_q    <= ST_IDLE;
            cmd_busy_q <= 1'b0;
          end
          ST_ALU_OPA: begin
            rf_wr_en_q   <= 1'b1;
            rf_addr_q    <= ADDR_WIDTH'(OPA_ADDR);
            rf_wr_data_q <= p_data;
            state_q      <= ST_ALU_OPB;
          end
          ST_ALU_OPB: begin
            rf_wr_en_q   <= 1'b1;
            rf_addr_q    <= ADDR_WIDTH'(OPB_ADDR);
            rf_wr_data_q <= p_data;
            state_q      <= ST_ALU_FUN;
          end
          ST_ALU_FUN, ST_NOP_FUN: begin
            alu_en_q   <= 1'b1;
            alu_fun_q  <= p_data[ALU_FUN_WIDTH-1:0];
            state_q    <= ST_IDLE;
            cmd_busy_q <= 1'b0;
          end
          default: begin
            state_q    <= ST_IDLE;
            cmd_busy_q <= 1'b0;
          end
        endcase
      end else if (in_cmd_s && timeout_s) begin
        state_q     <= ST_IDLE;
        cmd_busy_q  <= 1'b0;
        cmd_error_q <= 1'b1;
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign alu_en     = alu_en_q;
  assign alu_fun    = alu_fun_q;
  assign cmd_busy   = cmd_busy_q;
  assign cmd_error  = cmd_error_q;

endmodule : uart_rx_cmd_decoder

// File: tb/tb_uart_rx_cmd_decoder.sv
// Directed bench for uart_rx_cmd_decoder; outputs are packed as
// {wr_en, rd_en, alu_en, cmd_error, cmd_busy, rf_addr, rf_wr_data, alu_fun}.
module tb_uart_rx_cmd_decoder;

  logic       rx_clk;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic       cmd_busy;
  logic       cmd_error;

  logic [20:0] obs;
  logic [20:0] exp;
  int n_tests;
  int n_fail;

  assign obs = {rf_wr_en, rf_rd_en, alu_en, cmd_error, cmd_busy, rf_addr, rf_wr_data, alu_fun};

  uart_rx_cmd_decoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(4096)
  ) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .p_data(p_data), .data_valid(data_valid),
    .parity_error(parity_error), .stop_error(stop_error),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .cmd_busy(cmd_busy), .cmd_error(cmd_error)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  // One frame: valid for one cycle, returns at the negedge where its response is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge rx_clk);
    p_data = b;
    data_valid = 1'b1;
    @(negedge rx_clk);
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp = 21'h0; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL reset_state: obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_write();
    send_byte(8'hAA);
    exp = {5'b00001, 4'h0, 8'h00, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL wr_frame1: obs=%h exp=%h", obs, exp); end
    send_byte(8'h05);
    exp = {5'b00001, 4'h0, 8'h00, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL wr_frame2: obs=%h exp=%h", obs, exp); end
    send_byte(8'h19);
    exp = {5'b10000, 4'h5, 8'h19, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL wr_strobe: obs=%h exp=%h", obs, exp); end
    @(negedge rx_clk);
    exp = {5'b00000, 4'h5, 8'h19, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL wr_hold: obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_read();
    send_byte(8'hBB);
    exp = {5'b00001, 4'h5, 8'h19, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL rd_frame1: obs=%h exp=%h", obs, exp); end
    send_byte(8'h02);
    exp = {5'b01000, 4'h2, 8'h19, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL rd_strobe: obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_alu_op();
    send_byte(8'hCC);
    exp = {5'b00001, 4'h2, 8'h19, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL alu_frame1: obs=%h exp=%h", obs, exp); end
    send_byte(8'h0A);
    exp = {5'b10001, 4'h0, 8'h0A, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL alu_opa: obs=%h exp=%h", obs, exp); end
    send_byte(8'h0F);
    exp = {5'b10001, 4'h1, 8'h0F, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL alu_opb: obs=%h exp=%h", obs, exp); end
    send_byte(8'h00);
    exp = {5'b00100, 4'h1, 8'h0F, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL alu_fun0: obs=%h exp=%h", obs, exp); end
    for (int f = 1; f <= 4; f++) begin
      send_byte(8'hCC);
      send_byte(8'h0A);
      exp = {5'b10001, 4'h0, 8'h0A, 4'(f - 1)}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL alu_loop_opa f=%0d: obs=%h exp=%h", f, obs, exp); end
      send_byte(8'h0F);
      send_byte(8'(f));
      exp = {5'b00100, 4'h1, 8'h0F, 4'(f)}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL alu_loop_fun f=%0d: obs=%h exp=%h", f, obs, exp); end
    end
  endtask

  task automatic test_nop_and_idle();
    send_byte(8'hDD);
    exp = {5'b00001, 4'h1, 8'h0F, 4'h4}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL nop_frame1: obs=%h exp=%h", obs, exp); end
    send_byte(8'h03);
    exp = {5'b00100, 4'h1, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL nop_strobe: obs=%h exp=%h", obs, exp); end
    send_byte(8'h55);
    exp = {5'b00000, 4'h1, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL idle_unknown: obs=%h exp=%h", obs, exp); end
    @(negedge rx_clk); parity_error = 1'b1;
    @(negedge rx_clk); parity_error = 1'b0; stop_error = 1'b1;
    exp = {5'b00000, 4'h1, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL idle_parity: obs=%h exp=%h", obs, exp); end
    @(negedge rx_clk); stop_error = 1'b0;
    exp = {5'b00000, 4'h1, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL idle_stop: obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_error_abort();
    send_byte(8'hAA);
    send_byte(8'h05);
    @(negedge rx_clk); parity_error = 1'b1; data_valid = 1'b1; p_data = 8'h77;
    @(negedge rx_clk); parity_error = 1'b0; data_valid = 1'b0;
    exp = {5'b00010, 4'h1, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL abort_pulse: obs=%h exp=%h", obs, exp); end
    @(negedge rx_clk);
    exp = {5'b00000, 4'h1, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL abort_after: obs=%h exp=%h", obs, exp); end
    send_byte(8'hBB);
    send_byte(8'h01);
    exp = {5'b01000, 4'h1, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL abort_recover_rd: obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    @(negedge rx_clk); data_valid = 1'b1; p_data = 8'hBB;
    @(negedge rx_clk); p_data = 8'h03;
    exp = {5'b00001, 4'h1, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL b2b_busy: obs=%h exp=%h", obs, exp); end
    @(negedge rx_clk); p_data = 8'hDD;
    exp = {5'b01000, 4'h3, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL b2b_rd: obs=%h exp=%h", obs, exp); end
    @(negedge rx_clk); p_data = 8'h06;
    exp = {5'b00001, 4'h3, 8'h0F, 4'h3}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL b2b_decode: obs=%h exp=%h", obs, exp); end
    @(negedge rx_clk); data_valid = 1'b0;
    exp = {5'b00100, 4'h3, 8'h0F, 4'h6}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL b2b_alu: obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_timeout();
    int pulses;
    int first_err;
    pulses = 0;
    first_err = -1;
    send_byte(8'hCC);
    exp = {5'b00001, 4'h3, 8'h0F, 4'h6}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL tmo_start: obs=%h exp=%h", obs, exp); end
    for (int k = 1; k <= 4300; k++) begin
      @(negedge rx_clk);
      if (cmd_error === 1'b1) begin
        pulses++;
        if (first_err < 0) first_err = k;
      end
    end
    n_tests++; if (first_err !== 4096) begin n_fail++; $display("FAIL tmo_latency: got cycle %0d want 4096", first_err); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL tmo_pulses: got %0d want 1", pulses); end
    exp = {5'b00000, 4'h3, 8'h0F, 4'h6}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL tmo_idle: obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_timeout_vs_valid();
    send_byte(8'hCC);
    repeat (4095) @(negedge rx_clk);
    data_valid = 1'b1; p_data = 8'h0A;
    @(negedge rx_clk); data_valid = 1'b0;
    exp = {5'b10001, 4'h0, 8'h0A, 4'h6}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL tmo_valid_wins: obs=%h exp=%h", obs, exp); end
    send_byte(8'h0F);
    send_byte(8'h09);
    exp = {5'b00100, 4'h1, 8'h0F, 4'h9}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL tmo_valid_finish: obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hAA);
    send_byte(8'h05);
    exp = {5'b00001, 4'h1, 8'h0F, 4'h9}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL rst_mid_busy: obs=%h exp=%h", obs, exp); end
    #2 rst_n = 1'b0;
    #1;
    exp = 21'h0; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL rst_async_clear: obs=%h exp=%h", obs, exp); end
    @(negedge rx_clk); rst_n = 1'b1;
    send_byte(8'h19);
    exp = 21'h0; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL rst_discard: obs=%h exp=%h", obs, exp); end
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h33);
    exp = {5'b10000, 4'h7, 8'h33, 4'h0}; n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL rst_then_write: obs=%h exp=%h", obs, exp); end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    p_data = 8'h00;
    data_valid = 1'b0;
    parity_error = 1'b0;
    stop_error = 1'b0;
    repeat (2) @(negedge rx_clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge rx_clk);
    test_write();
    test_read();
    test_alu_op();
    test_nop_and_idle();
    test_error_abort();
    test_back_to_back();
    test_timeout();
    test_timeout_vs_valid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_cmd_decoder

// File: doc/uart_rx_cmd_decoder.md
Name: uart_rx_cmd_decoder

Overview:
- Consumes the byte stream from the UART receiver (p_data/data_valid plus error flags) and decodes multi-frame commands.
- Issues single-cycle register-file write/read requests and ALU operation requests to the system side.
- Sits directly downstream of the UART RX top and upstream of the register file and ALU.
- Supported commands: 0xAA write (3 frames), 0xBB read (2 frames), 0xCC ALU with operands (4 frames), 0xDD ALU without operands (2 frames).

Parameters:
- DATA_WIDTH, 8, UART payload width; also the register-file data width.
- ADDR_WIDTH, 4, register-file address width; the address byte is truncated to its low ADDR_WIDTH bits.
- ALU_FUN_WIDTH, 4, ALU function code width; the function byte is truncated to its low ALU_FUN_WIDTH bits.
- TIMEOUT_CYCLES, 4096, maximum rx_clk cycles between consecutive frames of one command before the command is aborted.

Ports:
- rx_clk  in  1  block clock; the same clock as the UART RX.
- rst_n  in  1  asynchronous, active-low reset.
- p_data  in  DATA_WIDTH  received byte; qualified by data_valid.
- data_valid  in  1  one-cycle strobe marking a good frame.
- parity_error  in  1  current frame has a parity error.
- stop_error  in  1  current frame has a stop-bit error.
- rf_wr_en  out  1  one-cycle register-file write strobe.
- rf_rd_en  out  1  one-cycle register-file read strobe.
- rf_addr  out  ADDR_WIDTH  register-file address.
- rf_wr_data  out  DATA_WIDTH  register-file write data.
- alu_en  out  1  one-cycle ALU operation strobe.
- alu_fun  out  ALU_FUN_WIDTH  ALU function code.
- cmd_busy  out  1  high while a command is partially received.
- cmd_error  out  1  one-cycle pulse on any command abort.

Behaviour:
- Clocking and reset: one clock, rx_clk. rst_n is asynchronous, active-low.
- Reset values: every output is 0; the FSM state is IDLE; the timeout counter is 0; the latched address is 0.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN, NOP_FUN.
- Transitions from IDLE on data_valid:
  - 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> ALU_OPA
  - 0xDD -> NOP_FUN
  - any other byte: stay in IDLE with no output and no cmd_error.
- Per-state actions on data_valid:
  - WR_ADDR: latch the address, go to WR_DATA.
  - WR_DATA: rf_wr_en=1, rf_addr=latched address, rf_wr_data=p_data; go to IDLE.
  - RD_ADDR: rf_rd_en=1, rf_addr=p_data; go to IDLE.
  - ALU_OPA: rf_wr_en=1, rf_addr=0, rf_wr_data=p_data; go to ALU_OPB.
  - ALU_OPB: rf_wr_en=1, rf_addr=1, rf_wr_data=p_data; go to ALU_FUN.
  - ALU_FUN and NOP_FUN: alu_en=1, alu_fun=p_data; go to IDLE.
- Latency: every strobe is registered and asserts exactly one cycle after the data_valid cycle that completes it.
- Output hold: rf_addr, rf_wr_data and alu_fun hold their last value after the strobe; they are not cleared.
- Strobe width: strobes are never longer than one cycle. At most one of rf_wr_en, rf_rd_en or alu_en is high in any cycle.
- cmd_busy: registered; high in every state except IDLE.
- Error abort: if parity_error or stop_error is high in any cycle while not in IDLE:
  - go to IDLE, pulse cmd_error, issue no strobe;
  - a data_valid in that same cycle is ignored.
- Errors in IDLE: dropped silently, no cmd_error.
- Timeout counter:
  - clears on every data_valid and in IDLE, increments otherwise.
  - reaching TIMEOUT_CYCLES-1 in a non-IDLE state forces IDLE and pulses cmd_error.
  - saturates; never wraps.
- Simultaneous events: timeout and data_valid in the same cycle -> data_valid wins and the frame is accepted.
- Back-to-back commands: a new command byte arriving in the cycle after a strobe is decoded normally; no idle gap is required.
- Reset mid-command: any partial command is discarded and no strobe is issued.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - command opcodes CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD;
  - the FSM state encoding;
  - operand addresses OPA_ADDR=0, OPB_ADDR=1.
- One natural sub-module: uart_cmd_timeout, the saturating inter-frame counter with a clear input and a timeout-pulse output.

Test Plan:
- Write command: frames AA,05,19 -> one cycle after the last data_valid: rf_wr_en=1, rf_addr=5, rf_wr_data=0x19; cmd_busy high from the first frame until the strobe.
- Read command: frames BB,02 -> rf_rd_en=1, rf_addr=2; no rf_wr_en or alu_en.
- ALU with operands: frames CC,0A,0F,00 -> rf_wr_en at addr 0 with data 0x0A, then rf_wr_en at addr 1 with data 0x0F, then alu_en=1 with alu_fun=0; repeat with function bytes 01..04 -> alu_fun=1..4.
- ALU without operands: frames DD,03 -> alu_en=1, alu_fun=3; glitch frames and unknown byte 0x55 in IDLE -> no outputs, no cmd_error.
- Error abort: frames AA,05 then parity_error pulse -> cmd_error pulses, FSM returns to IDLE, no rf_wr_en; following frames BB,01 -> rf_rd_en, addr 1.
- Timeout: frame CC then silence for TIMEOUT_CYCLES -> cmd_error pulses once and cmd_busy=0; asserting rst_n=0 mid-command clears every output asynchronously.
